// File: rtl/tone_frame_sched.sv
// tone_frame_sched
//   Frame scheduler for the voice-tone (pitch-shift) path. Owns the ping-pong
//   pair of frame RAMs: the write side steers sample writes into one bank while
//   the read side replays the previously completed bank with a mode-dependent
//   address pattern (bypass / stretch / compress) into the output FIFO.
//
// Ports
//   process_clk      processing clock
//   rst_n            asynchronous active-low reset
//   sample_stb       one-cycle pulse per incoming sample (already synchronised)
//   enable           write-side enable; strobes ignored while low
//   mode             0/3 bypass, 1 stretch, 2 compress
//   fifo_almost_full output FIFO back-pressure, sampled in the issue cycle
//   overrun_clr      clears the sticky overrun flag
//   wr_bank/wr_addr  bank and address being written
//   wr_en_a/wr_en_b  per-bank write enables (combinational)
//   rd_bank/rd_addr  bank and address being read
//   rd_en            rd_addr is a valid issue this cycle
//   fifo_wr_en       rd_en delayed by the 1-cycle RAM read latency
//   busy             read FSM not idle
//   overrun          sticky: a frame completed while the reader was busy
module tone_frame_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int FRAME_LEN  = 1024
) (
  input  logic                  process_clk,
  input  logic                  rst_n,
  input  logic                  sample_stb,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  fifo_almost_full,
  input  logic                  overrun_clr,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic                  fifo_wr_en,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO  = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic                    wr_bank_reg;
  logic [1:0]              rd_mode_reg;
  logic                    rd_bank_reg;
  logic [ADDR_WIDTH-1:0]   src_reg, src_next;
  logic [ADDR_WIDTH-1:0]   out_cnt_reg, out_cnt_next;
  logic                    dup_reg, dup_next;
  logic                    fifo_wr_en_reg;
  logic                    overrun_reg;
  logic                    accept;
  logic                    frame_done;
  logic                    issue;

  // ---------------- write side ----------------
  assign accept     = sample_stb & enable;
  assign frame_done = accept & (wr_addr_reg == LAST);
  assign wr_en_a    = accept & ~wr_bank_reg;
  assign wr_en_b    = accept &  wr_bank_reg;

  always_ff @(posedge process_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_reg <= '0;
      wr_bank_reg <= 1'b0;
      rd_mode_reg <= 2'd0;
      rd_bank_reg <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_done) begin
          wr_addr_reg <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_addr_reg <= wr_addr_reg + ONE;
        end
      end
      // Only capture read parameters for a frame that will actually be read,
      // so they stay stable for the whole read of the current frame.
      if (frame_done && (state_reg == IDLE)) begin
        rd_mode_reg <= mode;
        rd_bank_reg <= wr_bank_reg;
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge process_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      out_cnt_reg    <= '0;
      dup_reg        <= 1'b0;
      fifo_wr_en_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      out_cnt_reg    <= out_cnt_next;
      dup_reg        <= dup_next;
      fifo_wr_en_reg <= issue;
      // A completion while busy drops that frame; set beats clear.
      if (frame_done && (state_reg != IDLE))
        overrun_reg <= 1'b1;
      else if (overrun_clr)
        overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    src_next     = src_reg;
    out_cnt_next = out_cnt_reg;
    dup_next     = dup_reg;
    issue        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_done) begin
          state_next   = READ;
          src_next     = '0;
          out_cnt_next = '0;
          dup_next     = 1'b0;
        end
      end
      READ: begin
        if (!fifo_almost_full) begin
          issue        = 1'b1;
          out_cnt_next = out_cnt_reg + ONE;
          case (rd_mode_reg)
            2'd1: begin
              // Stretch: every 4th source word is emitted twice.
              if ((src_reg[1:0] == 2'd0) && !dup_reg) begin
                dup_next = 1'b1;
              end else begin
                src_next = src_reg + ONE;
                dup_next = 1'b0;
              end
            end
            2'd2: begin
              // Compress: skip the 4th word of every group of four.
              src_next = (src_reg[1:0] == 2'd2) ? src_reg + TWO : src_reg + ONE;
            end
            default: src_next = src_reg + ONE;
          endcase
          if (out_cnt_reg == LAST)
            state_next = DRAIN;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wr_addr    = wr_addr_reg;
  assign wr_bank    = wr_bank_reg;
  assign rd_bank    = rd_bank_reg;
  assign rd_addr    = src_reg;
  assign rd_en      = issue;
  assign fifo_wr_en = fifo_wr_en_reg;
  assign busy       = (state_reg != IDLE);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_tone_frame_sched.sv
// tb_tone_frame_sched
//   Directed bench for tone_frame_sched. Expected read addresses are pushed to
//   a queue when a frame is written; the negedge monitor records every issued
//   address, and each frame's issues are compared against the queue.
module tb_tone_frame_sched;

  logic       process_clk = 1'b0;
  logic       rst_n;
  logic       sample_stb;
  logic       enable;
  logic [1:0] mode;
  logic       fifo_almost_full;
  logic       overrun_clr;
  logic       wr_bank;
  logic [9:0] wr_addr;
  logic       wr_en_a;
  logic       wr_en_b;
  logic       rd_bank;
  logic [9:0] rd_addr;
  logic       rd_en;
  logic       fifo_wr_en;
  logic       busy;
  logic       overrun;

  tone_frame_sched #(.ADDR_WIDTH(10), .FRAME_LEN(1024)) dut (
    .process_clk      (process_clk),
    .rst_n            (rst_n),
    .sample_stb       (sample_stb),
    .enable           (enable),
    .mode             (mode),
    .fifo_almost_full (fifo_almost_full),
    .overrun_clr      (overrun_clr),
    .wr_bank          (wr_bank),
    .wr_addr          (wr_addr),
    .wr_en_a          (wr_en_a),
    .wr_en_b          (wr_en_b),
    .rd_bank          (rd_bank),
    .rd_addr          (rd_addr),
    .rd_en            (rd_en),
    .fifo_wr_en       (fifo_wr_en),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 process_clk = ~process_clk;

  // ---------------- monitor (owns its counters and observation log) -------
  int   busy_cnt = 0, rd_cnt = 0, fwr_cnt = 0, stall_viol = 0;
  int   wra_cnt = 0, wrb_cnt = 0;
  int   obs_addr[$];
  int   obs_bank[$];

  always @(negedge process_clk) begin
    if (busy === 1'b1)       busy_cnt <= busy_cnt + 1;
    if (fifo_wr_en === 1'b1) fwr_cnt  <= fwr_cnt + 1;
    if (wr_en_a === 1'b1)    wra_cnt  <= wra_cnt + 1;
    if (wr_en_b === 1'b1)    wrb_cnt  <= wrb_cnt + 1;
    if (rd_en === 1'b1 && fifo_almost_full === 1'b1) stall_viol <= stall_viol + 1;
    if (rd_en === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      obs_addr.push_back(int'(rd_addr));
      obs_bank.push_back(int'(rd_bank));
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  int exp_addr_q[$];
  int exp_bank_q[$];
  int obs_ptr = 0;
  int b_busy, b_rd, b_fwr, b_stall, b_wra, b_wrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_addr(input int m, input int i);
    int j;
    case (m)
      1: return 4 * (i / 5) + ((i % 5 == 0) ? 0 : (i % 5) - 1);
      2: begin
        j = i % 768;
        return 4 * (j / 3) + (j % 3);
      end
      default: return i;
    endcase
  endfunction

  task automatic push_frame(input int m, input int bank);
    for (int i = 0; i < 1024; i++) begin
      exp_addr_q.push_back(model_addr(m, i));
      exp_bank_q.push_back(bank);
    end
  endtask

  task automatic snap();
    b_busy = busy_cnt; b_rd = rd_cnt; b_fwr = fwr_cnt; b_stall = stall_viol;
    b_wra = wra_cnt; b_wrb = wrb_cnt;
  endtask

  // n cycles of stimulus; fifo_almost_full high for cycles [af_s, af_s+af_l)
  task automatic run_cycles(input int n, input logic stb, input int af_s, input int af_l);
    for (int i = 0; i < n; i++) begin
      @(posedge process_clk); #1;
      sample_stb       = stb;
      fifo_almost_full = (i >= af_s) && (i < af_s + af_l);
    end
    @(posedge process_clk); #1;
    sample_stb       = 1'b0;
    fifo_almost_full = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy === 1'b1 && c < 5000) begin
      @(posedge process_clk); #1;
      c++;
    end
    chk({tag, "_idle_in_time"}, 32'(c < 5000), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int exp_busy);
    int n, got_n, e_a, e_b;
    chk({tag, "_rd_en_count"}, rd_cnt - b_rd, 1024);
    chk({tag, "_fifo_wr_count"}, fwr_cnt - b_fwr, 1024);
    chk({tag, "_busy_cycles"}, busy_cnt - b_busy, exp_busy);
    chk({tag, "_issue_under_af"}, stall_viol - b_stall, 0);
    n     = exp_addr_q.size();
    got_n = obs_addr.size() - obs_ptr;
    chk({tag, "_seq_len"}, got_n, n);
    for (int k = 0; k < n && obs_ptr < obs_addr.size(); k++) begin
      e_a = exp_addr_q.pop_front();
      e_b = exp_bank_q.pop_front();
      chk($sformatf("%s_addr[%0d]", tag, k), obs_addr[obs_ptr], e_a);
      chk($sformatf("%s_bank[%0d]", tag, k), obs_bank[obs_ptr], e_b);
      obs_ptr++;
    end
    exp_addr_q.delete();
    exp_bank_q.delete();
    obs_ptr = obs_addr.size();
  endtask

  initial begin
    rst_n = 1'b0; sample_stb = 1'b0; enable = 1'b0; mode = 2'd0;
    fifo_almost_full = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge process_clk);
    #1;
    // reset state
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // ---- bypass, bank 0 ----
    mode = 2'd0;
    snap();
    push_frame(0, 0);
    run_cycles(1023, 1'b1, 0, 0);
    chk("byp_wr_addr_1023", wr_addr, 1023);
    chk("byp_wr_bank_before", wr_bank, 0);
    chk("byp_idle_before", busy, 0);
    run_cycles(1, 1'b1, 0, 0);
    chk("byp_wr_bank_after", wr_bank, 1);
    chk("byp_wr_addr_wrap", wr_addr, 0);
    chk("byp_busy_n1", busy, 1);
    chk("byp_rd_en_n1", rd_en, 1);
    chk("byp_rd_addr_n1", rd_addr, 0);
    chk("byp_fifo_wr_n1", fifo_wr_en, 0);
    @(posedge process_clk); #1;
    chk("byp_fifo_wr_n2", fifo_wr_en, 1);
    wait_idle("byp");
    chk("byp_wr_en_a_count", wra_cnt - b_wra, 1024);
    chk("byp_wr_en_b_count", wrb_cnt - b_wrb, 0);
    check_frame("byp", 1025);

    // ---- stretch, bank 1 ----
    mode = 2'd1;
    snap();
    push_frame(1, 1);
    run_cycles(1024, 1'b1, 0, 0);
    chk("str_wr_en_b_count", wrb_cnt - b_wrb, 1024);
    wait_idle("str");
    check_frame("str", 1025);

    // ---- compress, bank 0 ----
    mode = 2'd2;
    snap();
    push_frame(2, 0);
    run_cycles(1024, 1'b1, 0, 0);
    wait_idle("cmp");
    check_frame("cmp", 1025);

    // ---- back-pressure (mode 3 = bypass), bank 1 ----
    mode = 2'd3;
    snap();
    push_frame(3, 1);
    run_cycles(1024, 1'b1, 0, 0);
    run_cycles(200, 1'b0, 50, 20);
    wait_idle("bp");
    check_frame("bp", 1045);

    // ---- overrun: second frame completes mid-read ----
    mode = 2'd0;
    snap();
    push_frame(0, 0);
    run_cycles(1024, 1'b1, 0, 0);
    chk("ovr_clear_before", overrun, 0);
    run_cycles(1024, 1'b1, 100, 30);
    chk("ovr_set", overrun, 1);
    wait_idle("ovr");
    check_frame("ovr", 1055);
    run_cycles(20, 1'b0, 0, 0);
    chk("ovr_dropped_not_read", busy_cnt - b_busy, 1055);
    chk("ovr_sticky", overrun, 1);
    @(posedge process_clk); #1;
    overrun_clr = 1'b1;
    @(posedge process_clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_wr_bank", wr_bank, 0);

    // ---- enable hold/resume, then reset mid-read ----
    snap();
    run_cycles(500, 1'b1, 0, 0);
    chk("en_addr_500", wr_addr, 500);
    enable = 1'b0;
    run_cycles(10, 1'b1, 0, 0);
    chk("en_hold_500", wr_addr, 500);
    chk("en_no_writes", wra_cnt - b_wra, 500);
    enable = 1'b1;
    run_cycles(1, 1'b1, 0, 0);
    chk("en_resume_501", wr_addr, 501);
    run_cycles(523, 1'b1, 0, 0);
    chk("en_frame_read_started", busy, 1);
    run_cycles(50, 1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_fifo_wr_en", fifo_wr_en, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_rd_bank", rd_bank, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_bank", wr_bank, 0);
    chk("arst_overrun", overrun, 0);
    @(posedge process_clk); #1;
    rst_n = 1'b1;
    run_cycles(5, 1'b0, 0, 0);
    chk("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
